// File: rtl/cskip_adder_pipe_pkg.sv
// rtl/cskip_adder_pipe_pkg.sv - shared constants and parameter check for the pipelined carry-skip adder
package cskip_adder_pipe_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_BLK    = 4;
   localparam int DEF_STAGES = 2;

   localparam int SEG_W = DEF_WIDTH / DEF_STAGES;
   localparam int NBLK  = SEG_W / DEF_BLK;

   // True when the operand splits evenly into STAGES segments of whole skip blocks.
   function automatic bit params_ok(input int width, input int blk, input int stages);
      if (stages < 1 || blk < 1) begin
         return 1'b0;
      end
      return (width % (stages * blk)) == 0;
   endfunction

endpackage

// File: rtl/cskip_adder_pipe_block.sv
// rtl/cskip_adder_pipe_block.sv - one BLK-bit ripple block with a carry-skip bypass mux
module cskip_block
   import cskip_adder_pipe_pkg::*;
#(
   parameter int BLK = DEF_BLK
)
(
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           ci,
   output logic [BLK-1:0] s,
   output logic           co
);

   logic c_rip;
   logic rc;

   always_comb begin
      c_rip = ci;
      s     = '0;
      for (int i = 0; i < BLK; i++) begin
         s[i]  = a[i] ^ b[i] ^ c_rip;
         c_rip = (a[i] & b[i]) | (c_rip & (a[i] ^ b[i]));
      end
      rc = c_rip;
   end

   // When every bit propagates, the block carry-in passes straight through.
   assign co = (&(a ^ b)) ? ci : rc;

endmodule

// File: rtl/cskip_adder_pipe.sv
// rtl/cskip_adder_pipe.sv - pipelined carry-skip adder/subtractor with valid/ready on both sides
module cskip_adder_pipe
   import cskip_adder_pipe_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int BLK    = DEF_BLK,
   parameter int STAGES = DEF_STAGES
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int SW = WIDTH / STAGES;
   localparam int NB = SW / BLK;

   if (!params_ok(WIDTH, BLK, STAGES)) begin : g_bad_params
      $error("cskip_adder_pipe: WIDTH must be a multiple of STAGES*BLK");
   end

   logic             stall;
   logic             v0_r;
   logic             c0_r;
   logic [WIDTH-1:0] a0_r;
   logic [WIDTH-1:0] b0_r;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   // Operand capture: subtraction is folded in here so the stages only ever add.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_r <= 1'b0;
         c0_r <= 1'b0;
         a0_r <= '0;
         b0_r <= '0;
      end else if (!stall) begin
         v0_r <= in_valid;
         if (in_valid) begin
            a0_r <= x;
            b0_r <= sub ? ~y : y;
            c0_r <= sub | cin;
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int LO = k * SW;
      localparam int HW = WIDTH - LO;

      logic [HW-1:0]    a_i;
      logic [HW-1:0]    b_i;
      logic             c_i;
      logic             v_i;
      logic [SW-1:0]    seg_s;
      logic [LO+SW-1:0] s_cat;
      logic             v_r;
      logic             c_r;
      logic [LO+SW-1:0] s_r;

      for (genvar j = 0; j < NB; j++) begin : g_blk
         logic bci;
         logic bco;
         if (j == 0) begin : g_cin
            assign bci = c_i;
         end else begin : g_cin
            assign bci = g_blk[j-1].bco;
         end
         cskip_block #(.BLK(BLK)) u_blk (
            .a  (a_i[j*BLK +: BLK]),
            .b  (b_i[j*BLK +: BLK]),
            .ci (bci),
            .s  (seg_s[j*BLK +: BLK]),
            .co (bco)
         );
      end

      // a_i/b_i hold only the not-yet-added upper slices; s_cat grows by one slice per stage.
      if (k == 0) begin : g_src
         assign a_i   = a0_r;
         assign b_i   = b0_r;
         assign c_i   = c0_r;
         assign v_i   = v0_r;
         assign s_cat = seg_s;
      end else begin : g_src
         assign a_i   = g_stg[k-1].g_skew.a_r;
         assign b_i   = g_stg[k-1].g_skew.b_r;
         assign c_i   = g_stg[k-1].c_r;
         assign v_i   = g_stg[k-1].v_r;
         assign s_cat = {seg_s, g_stg[k-1].s_r};
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_r <= 1'b0;
            c_r <= 1'b0;
            s_r <= '0;
         end else if (!stall) begin
            v_r <= v_i;
            if (v_i) begin
               c_r <= g_blk[NB-1].bco;
               s_r <= s_cat;
            end
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [HW-SW-1:0] a_r;
         logic [HW-SW-1:0] b_r;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_r <= '0;
               b_r <= '0;
            end else if (!stall && v_i) begin
               a_r <= a_i[HW-1:SW];
               b_r <= b_i[HW-1:SW];
            end
         end
      end

      // Carry into the MSB is recovered as a^b^s at that bit.
      if (k == STAGES - 1) begin : g_flag
         logic ovf_r;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_r <= 1'b0;
            end else if (!stall && v_i) begin
               ovf_r <= a_i[HW-1] ^ b_i[HW-1] ^ seg_s[SW-1] ^ g_blk[NB-1].bco;
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].v_r;
   assign s         = g_stg[STAGES-1].s_r;
   assign cout      = g_stg[STAGES-1].c_r;
   assign ovf       = g_stg[STAGES-1].g_flag.ovf_r;

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// tb/tb_cskip_adder_pipe.sv - scoreboard bench for the pipelined carry-skip adder
module tb_cskip_adder_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x;
   logic [15:0] y;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] s;
   logic        cout;
   logic        ovf;

   int          total  = 0;
   int          passed = 0;
   logic [17:0] exp_q[$];
   logic [17:0] mon_e;

   always #5 clk = ~clk;

   cskip_adder_pipe #(.WIDTH(16), .BLK(4), .STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every output transfer pops one expected result.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_output: got s=%h cout=%b ovf=%b expected none", s, cout, ovf);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", {14'd0, s, cout, ovf}, {14'd0, mon_e});
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted the beat.
   task automatic send(input logic [15:0] xv, input logic [15:0] yv, input logic ci, input logic sb,
                       input logic [15:0] es, input logic ec, input logic eo);
      int  n;
      logic acc;
      x        = xv;
      y        = yv;
      cin      = ci;
      sub      = sb;
      in_valid = 1'b1;
      n        = 0;
      acc      = 1'b0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         n++;
      end
      if (acc) begin
         exp_q.push_back({es, ec, eo});
      end else begin
         total++;
         $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected 1", n);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic send_lat(input logic [15:0] xv, input logic [15:0] yv, input logic ci, input logic sb,
                           input logic [15:0] es, input logic ec, input logic eo);
      send(xv, yv, ci, sb, es, ec, eo);
      @(negedge clk);
      check("latency_edge0", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("latency_edge1", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("latency_edge2", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x         = '0;
      y         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      #1 rst_n  = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_s", {16'd0, s}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;

      send_lat(16'hA0A0, 16'hA0A0, 1'b0, 1'b0, 16'h4140, 1'b1, 1'b1);
      send(16'h58F4, 16'hF4F4, 1'b0, 1'b0, 16'h4DE8, 1'b1, 1'b0);
      send(16'h0F3D, 16'h0F0F, 1'b0, 1'b0, 16'h1E4C, 1'b0, 1'b0);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      send(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      send(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
      send(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
      drain();

      out_ready = 1'b0;
      fork
         begin
            send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
            send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0);
            send(16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0);
            send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
         end
         begin
            int n;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!out_valid && n < 20);
            check("stall_first_valid", {31'd0, out_valid}, 32'd1);
            for (int i = 0; i < 3; i++) begin
               check("stall_in_ready", {31'd0, in_ready}, 32'd0);
               check("stall_s_hold", {16'd0, s}, 32'h3333);
               if (i < 2) @(negedge clk);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      send(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);
      send(16'h0404, 16'h0505, 1'b0, 1'b0, 16'h0909, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_s", {16'd0, s}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      check("midrst_hold_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midrst_no_stale", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      send_lat(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cskip_adder_pipe.md
Name: cskip_adder_pipe

Overview:
Parametrised, pipelined carry-skip adder/subtractor. It is the successor to the fixed 16-bit combinational carry-skip adder. The operand width is split into STAGES register-separated segments, and each segment is built from BLK-bit skip blocks. A valid/ready handshake sits on both sides. It produces sum, carry-out and signed overflow, and serves as the arithmetic core for the datapath.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES*BLK.
BLK, 4, skip-block size in bits.
STAGES, 2, pipeline segments; latency in cycles; must be >= 1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  operand beat valid.
in_ready  output  1  block accepts beat this cycle.
x  input  WIDTH  operand A.
y  input  WIDTH  operand B.
cin  input  1  carry-in (ignored when sub=1).
sub  input  1  1: compute x - y as x + ~y + 1.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
s  output  WIDTH  sum/difference.
cout  output  1  carry out of MSB; in sub mode 1 = no borrow.
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Single clock; one clk, reset asynchronous active-low (rst_n).
- Reset: all stage valid bits 0, all data/carry registers 0.
  - Outputs during and after reset: out_valid=0, s=0, cout=0, ovf=0, in_ready=1.
  - Reset mid-operation discards every in-flight beat; no partial result ever appears.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stall condition: stall = out_valid && !out_ready. The whole pipe freezes under stall.
  - in_ready = !stall (combinational).
  - No bubble collapsing is required.
  - Holding registers keep s/cout/ovf stable while stalled.
- Datapath:
  - Effective B = sub ? ~y : y.
  - Effective carry-in = sub ? 1 : cin.
- Stage k (0..STAGES-1) adds bit slice [k*W/STAGES +: W/STAGES] using the registered carry from stage k-1. Stage 0 uses the effective cin.
- Operand skew and result alignment:
  - Upper operand slices are delayed through skew registers so each slice meets its carry.
  - Lower result slices are delayed so s emerges aligned.
- Inside a stage: ripple through BLK-bit blocks. Block carry-out = (all P bits of block) ? block carry-in : ripple carry-out, where P = a^b per bit.
- Latency: a beat accepted at edge n gives out_valid=1 after edge n+STAGES, absent stalls. Throughput is 1 beat/cycle.
- Result flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
- Width rules: no truncation except the discarded carry beyond cout; all arithmetic is modulo 2^WIDTH.
- Back-to-back mix of add/sub beats: per-beat sub travels with its beat; no cross-beat interference.
- Wrap-around: 0xFFFF+0x0001 gives s=0x0000, cout=1, ovf=0.
- Simultaneous input accept and output drain in the same cycle is legal and must not drop or duplicate beats.
- Illegal parameters (WIDTH % (STAGES*BLK) != 0) are rejected at elaboration.

Decomposition:
- Shared package holds:
  - default WIDTH/BLK/STAGES constants;
  - the derived SEG_W = WIDTH/STAGES;
  - NBLK = SEG_W/BLK;
  - an elaboration-check function for the divisibility rule.
- One sub-module: cskip_block (BLK-bit ripple plus skip mux, combinational). It is instantiated NBLK times per stage by generate loops.
- Pipeline/handshake control lives in the top level.

Test Plan:
- Add, WIDTH=16, STAGES=2: x=0xA0A0, y=0xA0A0, sub=0, cin=0 -> after 2 cycles s=0x4140, cout=1, ovf=1.
- Add: x=0x58F4, y=0xF4F4 -> s=0x4DE8, cout=1, ovf=0. Next beat back-to-back x=0x0F3D, y=0x0F0F -> s=0x1E4C, cout=0, ovf=0. Both beats arrive on consecutive cycles.
- Full skip chain across stage boundary: x=0x7FFF, y=0x0001 -> s=0x8000, cout=0, ovf=1. Then x=0xFFFF, y=0x0001 -> s=0x0000, cout=1, ovf=0.
- Subtract: x=0x0000, y=0x0001, sub=1 -> s=0xFFFF, cout=0, ovf=0. Then x=0x8000, y=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
- Backpressure: stream 4 beats with out_ready=0 for 3 cycles after first out_valid. Required response:
  - in_ready drops while stalled;
  - s holds its value;
  - all 4 results arrive in order with none lost or duplicated.
- Reset mid-flight: 2 beats in pipe, pulse rst_n low between edges -> out_valid=0, s=0 immediately. After release, only new beats appear with correct latency.
